uart_byte_receive: RTL and testbench
====================================

Name: uart_byte_receive

Overview:
- Receive-side counterpart of uart_byte_transmit: deserializes NUM_BYTES consecutive 8N1 UART frames from the host (FTDI2232) into one word.
- Used for host-to-FPGA control: steering angle, delay coefficients, mode bits.
- Sits between the uart_rxd pin and the top-level control registers in the clk_100mhz domain.
- Provides an internal synchronizer, start-bit validation, framing-error detection, and a single-cycle valid strobe per assembled word.

Parameters:
- INPUT_CLOCK_FREQ, 100_000_000, clk_in frequency in Hz.
- BAUD_RATE, 921_600, line rate in bit/s. CYCLES_PER_BIT = INPUT_CLOCK_FREQ / BAUD_RATE, integer floor; 108 at the defaults.
- NUM_BYTES, 2, frames per assembled word (>=1).
- TIMEOUT_BITS, 32, allowed idle gap between bytes of one word, in bit times. Used only with the optional feature.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- rx_wire_in  input  1  raw UART line; idle high; asynchronous to clk_in
- data_out  output  8*NUM_BYTES  last complete word. First received byte in [7:0], byte k in [8k+7:8k].
- data_valid_out  output  1  one-cycle pulse when data_out updates
- framing_error_out  output  1  one-cycle pulse on a bad stop bit
- timeout_out  output  1  one-cycle pulse when a partial word is discarded (optional feature)

Behaviour:
- Reset:
  - Both synchronizer flops = 1.
  - data_out = 0; all pulses = 0.
  - State IDLE; byte_idx = 0; bit counter and cycle counter = 0.
  - Reset asserted mid-frame or mid-word abandons everything; the partial word is never emitted.
- Synchronizer: 2-flop. The FSM sees rx_sync two cycles after rx_wire_in.
- IDLE: on rx_sync == 0, clear the cycle counter and go to START.
- START:
  - At count CYCLES_PER_BIT/2 - 1 (midpoint), sample rx_sync.
  - If 1: false start; go to IDLE with no pulses and byte_idx unchanged.
  - If 0: clear counter and go to DATA.
- DATA:
  - Sample rx_sync each time the counter reaches CYCLES_PER_BIT - 1, i.e. each bit midpoint.
  - Shift into the byte register LSB first.
  - After the 8th sample, go to STOP.
- STOP: sample at the next midpoint.
  - Sample == 1, byte_idx < NUM_BYTES-1: store the byte into the word register at byte_idx, byte_idx++, go to IDLE.
  - Sample == 1, byte_idx == NUM_BYTES-1: on the next cycle, data_out = assembled word and data_valid_out = 1 for exactly one cycle; byte_idx = 0; go to IDLE.
  - Sample == 0: framing_error_out = 1 for one cycle. Discard the partial word, byte_idx = 0, go to IDLE. The line may still be low; IDLE treats it as a new start, and START rejects it if it is high at the midpoint.
- Back-to-back frames: returning to IDLE at the stop-bit midpoint leaves a half bit of margin, so a next start edge immediately after the stop bit is caught.
- Latency: data_valid_out rises 2 + 9*CYCLES_PER_BIT + CYCLES_PER_BIT/2 + 1 cycles (+/-1 for edge alignment) after the last byte's start edge on rx_wire_in.
- data_out holds its value between valid pulses. It is never partially updated.
- Pulse exclusivity: data_valid_out, framing_error_out and timeout_out are mutually exclusive in any cycle.

Optional Feature:
- Macro: UART_BYTE_RX_TIMEOUT_EN.
- Defined:
  - A gap counter runs while in IDLE with byte_idx != 0.
  - When it reaches TIMEOUT_BITS*CYCLES_PER_BIT: byte_idx = 0, timeout_out pulses for one cycle, partial word discarded.
  - The gap counter clears on any start detection.
  - If a start edge and the timeout occur in the same cycle, the start wins.
- Undefined: no gap counter; timeout_out tied 0; a partial word waits indefinitely.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP}.
  - Function cycles_per_bit(freq, baud).
  - Constant UART_DATA_BITS = 8.
- One natural sub-module: uart_rx_byte.
  - Contains the synchronizer, FSM and bit sampling.
  - Outputs byte_out, byte_valid and frame_err.
  - uart_byte_receive adds the byte_idx word assembly and the timeout.

Test Plan:
- Defaults; send 0x34 then 0xAB back-to-back at 921_600 -> one data_valid_out pulse, data_out = 0xAB34, no error pulses.
- 20-cycle low glitch on an idle line -> no pulses, FSM back in IDLE; then a valid word 0x0102 (bytes 0x02, 0x01) -> data_out = 0x0102.
- First byte 0x55 with stop bit driven 0 -> framing_error_out one pulse; next full word 0x1234 -> data_out = 0x1234 (0x55 discarded).
- Assert rst_in during bit 4 of byte 2 of word 0xBEEF -> no valid pulse, data_out = 0; following word 0x00FF -> data_out = 0x00FF.
- With UART_BYTE_RX_TIMEOUT_EN and TIMEOUT_BITS=32: send 0x11, idle 40 bit times -> timeout_out pulse at 32 bit times; then 0x22, 0x33 -> data_out = 0x3322.
- NUM_BYTES=1; send 0x00 and 0xFF consecutively -> two valid pulses, data_out 0x00 then 0xFF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive types and helpers: FSM state encoding, data width and bit-period arithmetic.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Floor division gives the whole number of clock cycles per bit period.
  function automatic int cycles_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_receive_if.sv
// Output bundle of the word receiver: assembled word plus its three one-cycle status strobes.
interface uart_byte_receive_if #(
  parameter int NUM_BYTES = 2
);

  logic [8*NUM_BYTES-1:0] data_out;
  logic                   data_valid_out;
  logic                   framing_error_out;
  logic                   timeout_out;

  modport master (
    output data_out,
    output data_valid_out,
    output framing_error_out,
    output timeout_out
  );

  modport slave (
    input data_out,
    input data_valid_out,
    input framing_error_out,
    input timeout_out
  );

endinterface

// File: rtl/uart_rx_byte.sv
// Single 8N1 frame receiver: 2-flop synchronizer, midpoint sampling FSM, byte/frame-error strobes.
// With UART_BYTE_RX_TIMEOUT_EN it also exposes idle/start status for the inter-byte gap timer.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 108
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_wire_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
`ifdef UART_BYTE_RX_TIMEOUT_EN
  ,
  output logic       rx_idle,
  output logic       start_det
`endif
);

  localparam int CW = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [CW-1:0] MID_CNT = CW'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END = CW'(CYCLES_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_sync;

  assign rx_sync = sync2_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    sync1_d      = rx_wire_in;
    sync2_d      = sync1_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_sync) state_d = START;
      end
      // A line that is high again at the start-bit midpoint was only a glitch.
      START: begin
        if (cnt_q == MID_CNT) begin
          cnt_d   = '0;
          state_d = rx_sync ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // Leaving at the stop midpoint keeps half a bit of margin for a back-to-back start.
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d        = '0;
          state_d      = IDLE;
          byte_valid_d = rx_sync;
          frame_err_d  = ~rx_sync;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_out   = shift_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

`ifdef UART_BYTE_RX_TIMEOUT_EN
  assign rx_idle   = (state_q == IDLE);
  assign start_det = (state_q == IDLE) && !rx_sync;
`endif

endmodule

// File: rtl/uart_byte_receive.sv
// Assembles NUM_BYTES received UART frames (first byte in the low lane) into one word.
// Optional inter-byte gap timeout enabled by defining UART_BYTE_RX_TIMEOUT_EN.
module uart_byte_receive
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 921_600,
  parameter int NUM_BYTES        = 2,
  parameter int TIMEOUT_BITS     = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rx_wire_in,
  uart_byte_receive_if.master  rx_if
);

  localparam int CPB    = cycles_per_bit(INPUT_CLOCK_FREQ, BAUD_RATE);
  localparam int WORD_W = UART_DATA_BITS * NUM_BYTES;
  localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  if (NUM_BYTES < 1 || TIMEOUT_BITS < 1 || CPB < 4) begin : g_param_check
    $error("uart_byte_receive: NUM_BYTES/TIMEOUT_BITS must be >= 1 and a bit period >= 4 cycles");
  end

  logic [7:0]        rx_byte;
  logic              rx_byte_valid;
  logic              rx_frame_err;

  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

`ifdef UART_BYTE_RX_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CPB;
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic              rx_idle;
  logic              start_det;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              timeout_q, timeout_d;
`endif

  uart_rx_byte #(
    .CYCLES_PER_BIT(CPB)
  ) u_rx_byte (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rx_wire_in (rx_wire_in),
    .byte_out   (rx_byte),
    .byte_valid (rx_byte_valid),
    .frame_err  (rx_frame_err)
`ifdef UART_BYTE_RX_TIMEOUT_EN
    ,
    .rx_idle    (rx_idle),
    .start_det  (start_det)
`endif
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      word_q     <= '0;
      data_q     <= '0;
      byte_idx_q <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_BYTE_RX_TIMEOUT_EN
      gap_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      word_q     <= word_d;
      data_q     <= data_d;
      byte_idx_q <= byte_idx_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
`ifdef UART_BYTE_RX_TIMEOUT_EN
      gap_q      <= gap_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // data_out only changes as a whole word, so partial bytes live in word_q until the last one lands.
  always_comb begin
    word_d     = word_q;
    data_d     = data_q;
    byte_idx_d = byte_idx_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_BYTE_RX_TIMEOUT_EN
    gap_d      = '0;
    timeout_d  = 1'b0;
`endif

    if (rx_byte_valid) begin
      if (byte_idx_q == LAST_IDX) begin
        data_d = word_q;
        data_d[int'(byte_idx_q)*UART_DATA_BITS +: UART_DATA_BITS] = rx_byte;
        valid_d    = 1'b1;
        byte_idx_d = '0;
        word_d     = '0;
      end else begin
        word_d[int'(byte_idx_q)*UART_DATA_BITS +: UART_DATA_BITS] = rx_byte;
        byte_idx_d = byte_idx_q + IDX_W'(1);
      end
    end else if (rx_frame_err) begin
      ferr_d     = 1'b1;
      byte_idx_d = '0;
      word_d     = '0;
    end
`ifdef UART_BYTE_RX_TIMEOUT_EN
    // A start edge restarts the gap timer, so it wins over a coincident expiry.
    else if (rx_idle && !start_det && byte_idx_q != '0) begin
      if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_d  = 1'b1;
        byte_idx_d = '0;
        word_d     = '0;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end
`endif
  end

  assign rx_if.data_out          = data_q;
  assign rx_if.data_valid_out    = valid_q;
  assign rx_if.framing_error_out = ferr_q;
`ifdef UART_BYTE_RX_TIMEOUT_EN
  assign rx_if.timeout_out       = timeout_q;
`else
  assign rx_if.timeout_out       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_receive.sv
// Scoreboard bench for uart_byte_receive: a 2-byte and a 1-byte receiver share one serial line.
// Define UART_BYTE_RX_TIMEOUT_EN to include the inter-byte timeout scenario.
module tb_uart_byte_receive;

  localparam int CLK_HZ       = 100_000_000;
  localparam int BAUD         = 921_600;
  localparam int CPB          = CLK_HZ / BAUD;
  localparam int TIMEOUT_BITS = 32;

  typedef struct {
    int          kind;
    logic [15:0] data;
  } exp_t;

  localparam int K_WORD  = 0;
  localparam int K_FERR  = 1;
  localparam int K_TOUT  = 2;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rx_wire_in = 1'b1;

  int n_compared = 0;
  int n_mismatch = 0;

  exp_t        exp_q1[$];
  exp_t        exp_q2[$];
  logic [7:0]  part1[$];

  always #5 clk_in = ~clk_in;

  uart_byte_receive_if #(.NUM_BYTES(2)) if2b ();
  uart_byte_receive_if #(.NUM_BYTES(1)) if1b ();

  uart_byte_receive #(
    .INPUT_CLOCK_FREQ(CLK_HZ),
    .BAUD_RATE       (BAUD),
    .NUM_BYTES       (2),
    .TIMEOUT_BITS    (TIMEOUT_BITS)
  ) dut_word (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rx_wire_in(rx_wire_in),
    .rx_if     (if2b)
  );

  uart_byte_receive #(
    .INPUT_CLOCK_FREQ(CLK_HZ),
    .BAUD_RATE       (BAUD),
    .NUM_BYTES       (1),
    .TIMEOUT_BITS    (TIMEOUT_BITS)
  ) dut_byte (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rx_wire_in(rx_wire_in),
    .rx_if     (if1b)
  );

  function automatic exp_t mk(input int kind, input logic [15:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    return e;
  endfunction

  // Reference model at frame level: a good frame appends a byte, a bad stop bit wipes the word.
  function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) begin
      part1.push_back(b);
      if (part1.size() == 2) begin
        exp_q1.push_back(mk(K_WORD, {part1[1], part1[0]}));
        part1.delete();
      end
      exp_q2.push_back(mk(K_WORD, {8'h00, b}));
    end else begin
      part1.delete();
      exp_q1.push_back(mk(K_FERR, 16'h0));
      exp_q2.push_back(mk(K_FERR, 16'h0));
    end
  endfunction

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
    end
  endfunction

  task automatic drive(input logic v, input int cycles);
    rx_wire_in = v;
    repeat (cycles) @(posedge clk_in);
    #1;
  endtask

  task automatic idle_bits(input int n);
`ifdef UART_BYTE_RX_TIMEOUT_EN
    if (n > TIMEOUT_BITS + 1 && part1.size() != 0) begin
      part1.delete();
      exp_q1.push_back(mk(K_TOUT, 16'h0));
    end
`endif
    drive(1'b1, n * CPB);
  endtask

  // abort_bit >= 0 pulses reset halfway through that data bit and abandons the frame.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int abort_bit);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        drive(b[i], CPB / 2);
        rst_in = 1'b1;
        rx_wire_in = 1'b1;
        part1.delete();
        repeat (4) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        return;
      end
      drive(b[i], CPB);
    end
    model_frame(b, stop_ok);
    drive(stop_ok, CPB);
    if (!stop_ok) idle_bits(2);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_frame(w[7:0], 1'b1, -1);
    send_frame(w[15:8], 1'b1, -1);
  endtask

  task automatic mon(input int which, input logic v, input logic f, input logic t, input logic [15:0] d);
    exp_t e;
    int   kind;
    if (v || f || t) begin
      check($sformatf("pulse_exclusive_dut%0d", which), 16'(int'(v) + int'(f) + int'(t)), 16'd1);
      kind = v ? K_WORD : (f ? K_FERR : K_TOUT);
      n_compared++;
      if ((which == 1 && exp_q1.size() == 0) || (which == 2 && exp_q2.size() == 0)) begin
        n_mismatch++;
        $display("[TB] FAIL unexpected_event_dut%0d: got kind %0d data 0x%04h, expected none", which, kind, d);
      end else begin
        e = (which == 1) ? exp_q1.pop_front() : exp_q2.pop_front();
        if (e.kind != kind || (kind == K_WORD && e.data !== d)) begin
          n_mismatch++;
          $display("[TB] FAIL event_dut%0d: got kind %0d data 0x%04h, expected kind %0d data 0x%04h",
                   which, kind, d, e.kind, e.data);
        end
      end
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_in) begin
      mon(1, if2b.data_valid_out, if2b.framing_error_out, if2b.timeout_out, if2b.data_out);
      mon(2, if1b.data_valid_out, if1b.framing_error_out, if1b.timeout_out, {8'h00, if1b.data_out});
    end
  end

  task automatic check_reset_state(input string tag);
    @(negedge clk_in);
    check({tag, "_data_word"}, if2b.data_out, 16'h0000);
    check({tag, "_data_byte"}, {8'h00, if1b.data_out}, 16'h0000);
    check({tag, "_pulses"}, {13'h0, if2b.data_valid_out, if2b.framing_error_out, if2b.timeout_out}, 16'h0);
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus();
    logic [7:0] b;
    // Back-to-back frames forming one word.
    send_word(16'hAB34);
    idle_bits(2);
    // Short low glitch must be rejected at the start-bit midpoint.
    drive(1'b0, 20);
    idle_bits(2);
    send_word(16'h0102);
    idle_bits(2);
    // Bad stop bit on the first byte discards it.
    send_frame(8'h55, 1'b0, -1);
    send_word(16'h1234);
    idle_bits(2);
    // Reset during bit 4 of the second byte of 0xBEEF.
    send_frame(8'hEF, 1'b1, -1);
    send_frame(8'hBE, 1'b1, 4);
    check_reset_state("midword_reset");
    idle_bits(1);
    send_word(16'h00FF);
    idle_bits(2);
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle_bits(2);
`ifdef UART_BYTE_RX_TIMEOUT_EN
    send_frame(8'h11, 1'b1, -1);
    idle_bits(40);
    send_word(16'h3322);
    idle_bits(2);
`endif
    for (int w = 0; w < 10; w++) begin
      for (int k = 0; k < 2; k++) begin
        b = 8'($urandom_range(0, 255));
        send_frame(b, ($urandom_range(0, 7) != 0), -1);
        idle_bits(int'($urandom_range(0, 2)));
      end
    end
    idle_bits(2);
  endtask

  task automatic checkOutput();
    int budget = 0;
    while ((exp_q1.size() != 0 || exp_q2.size() != 0) && budget < 20000) begin
      @(posedge clk_in);
      budget++;
    end
    check("pending_word_events", 16'(exp_q1.size()), 16'd0);
    check("pending_byte_events", 16'(exp_q2.size()), 16'd0);
  endtask

  initial begin
    rst_in = 1'b1;
    rx_wire_in = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    check_reset_state("reset");
    applyStimulus();
    checkOutput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
